// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared memory-op codes and memory-stage FSM encodings
package mem_stage_pkg;

    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane steering, load extract/extend and alignment check
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_op_e           op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              misaligned_o,
    output logic [3:0]        wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rd_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        is_load_o    = 1'b0;
        is_store_o   = 1'b0;
        misaligned_o = 1'b0;
        wstrb_o      = 4'b0000;
        wdata_o      = '0;
        ld_data_o    = '0;
        case (op_i)
            MEM_LB: begin
                is_load_o = 1'b1;
                ld_data_o = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            end
            MEM_LBU: begin
                is_load_o = 1'b1;
                ld_data_o = {{(DATA_W-8){1'b0}}, rd_byte};
            end
            MEM_LH: begin
                is_load_o    = 1'b1;
                misaligned_o = addr_lo_i[0];
                ld_data_o    = {{(DATA_W-16){rd_half[15]}}, rd_half};
            end
            MEM_LHU: begin
                is_load_o    = 1'b1;
                misaligned_o = addr_lo_i[0];
                ld_data_o    = {{(DATA_W-16){1'b0}}, rd_half};
            end
            MEM_LW: begin
                is_load_o    = 1'b1;
                misaligned_o = |addr_lo_i;
                ld_data_o    = rdata_i;
            end
            MEM_SB: begin
                is_store_o = 1'b1;
                wstrb_o    = 4'b0001 << addr_lo_i;
                wdata_o    = {(DATA_W/8){wdata_i[7:0]}};
            end
            MEM_SH: begin
                is_store_o   = 1'b1;
                misaligned_o = addr_lo_i[0];
                wstrb_o      = 4'b0011 << addr_lo_i;
                wdata_o      = {(DATA_W/16){wdata_i[15:0]}};
            end
            MEM_SW: begin
                is_store_o   = 1'b1;
                misaligned_o = |addr_lo_i;
                wstrb_o      = 4'b1111;
                wdata_o      = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: one outstanding bus access, registered write-back
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [DATA_W-1:0] reg_write_data_i,
    input  logic [REG_AW-1:0] reg_write_addr_i,
    input  logic              reg_write_en_i,
    output logic              stall_req_o,
    output logic              addr_err_o,
    output logic              data_req_valid_o,
    input  logic              data_req_ready_i,
    output logic              data_req_wr_o,
    output logic [DATA_W-1:0] data_req_addr_o,
    output logic [3:0]        data_req_wstrb_o,
    output logic [DATA_W-1:0] data_req_wdata_o,
    input  logic              data_resp_valid_i,
    input  logic [DATA_W-1:0] data_resp_rdata_i,
    output logic [DATA_W-1:0] wb_write_data_o,
    output logic [REG_AW-1:0] wb_write_addr_o,
    output logic              wb_write_en_o
);

    mem_state_e        state_q, state_d;
    mem_op_e           op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rw_data_q;
    logic [REG_AW-1:0] rw_addr_q;
    logic              rw_en_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic              wb_en_q;
    logic              addr_err_q;

    // In IDLE the aligner checks the incoming op; afterwards it works on the latched one.
    mem_op_e           al_op;
    logic [1:0]        al_addr_lo;
    logic [DATA_W-1:0] al_wdata;
    logic              al_is_load, al_is_store, al_misaligned;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata_o, al_ld_data;
    logic              new_mem, take_access, resp_done;

    assign al_op      = (state_q == ST_IDLE) ? mem_op_e'(mem_op_i) : op_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? mem_addr_i[1:0] : addr_q[1:0];
    assign al_wdata   = (state_q == ST_IDLE) ? mem_wdata_i : wdata_q;

    mem_align #(.DATA_W(DATA_W)) u_align (
        .op_i         (al_op),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (al_wdata),
        .rdata_i      (data_resp_rdata_i),
        .is_load_o    (al_is_load),
        .is_store_o   (al_is_store),
        .misaligned_o (al_misaligned),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata_o),
        .ld_data_o    (al_ld_data)
    );

    assign new_mem     = (state_q == ST_IDLE) && (al_is_load || al_is_store);
    assign take_access = new_mem && !al_misaligned;
    assign resp_done   = (state_q == ST_RESP) && data_resp_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (take_access)       state_d = ST_REQ;
            ST_REQ:  if (data_req_ready_i)  state_d = ST_RESP;
            ST_RESP: if (data_resp_valid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req_o      = 1'b0;
        data_req_valid_o = 1'b0;
        data_req_wr_o    = 1'b0;
        data_req_addr_o  = '0;
        data_req_wstrb_o = 4'b0000;
        data_req_wdata_o = '0;
        case (state_q)
            ST_IDLE: stall_req_o = take_access;
            ST_REQ: begin
                stall_req_o      = 1'b1;
                data_req_valid_o = 1'b1;
                data_req_wr_o    = al_is_store;
                data_req_addr_o  = {addr_q[DATA_W-1:2], 2'b00};
                data_req_wstrb_o = al_wstrb;
                data_req_wdata_o = al_wdata_o;
            end
            ST_RESP: stall_req_o = !data_resp_valid_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= MEM_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_data_q  <= '0;
            rw_addr_q  <= '0;
            rw_en_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            wb_en_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= new_mem && al_misaligned;
            if (take_access) begin
                op_q      <= mem_op_e'(mem_op_i);
                addr_q    <= mem_addr_i;
                wdata_q   <= mem_wdata_i;
                rw_data_q <= reg_write_data_i;
                rw_addr_q <= reg_write_addr_i;
                rw_en_q   <= reg_write_en_i;
            end
            if (state_q == ST_IDLE) begin
                wb_data_q <= reg_write_data_i;
                wb_addr_q <= reg_write_addr_i;
                wb_en_q   <= reg_write_en_i && !new_mem;
            end else if (resp_done) begin
                wb_data_q <= al_is_load ? al_ld_data : rw_data_q;
                wb_addr_q <= rw_addr_q;
                wb_en_q   <= rw_en_q;
            end else begin
                wb_en_q   <= 1'b0;
            end
        end
    end

    assign addr_err_o      = addr_err_q;
    assign wb_write_data_o = wb_data_q;
    assign wb_write_addr_o = wb_addr_q;
    assign wb_write_en_o   = wb_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, reg_data;
    logic [4:0]  reg_addr;
    logic        reg_en;
    logic        stall, addr_err, req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_en;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                           OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                           OP_SW = 4'd8;

    // observations captured by do_access
    logic        o_seen, o_wr, o_done, o_stall_resp;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    int          o_stall_cnt;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_op_i          (mem_op),
        .mem_addr_i        (mem_addr),
        .mem_wdata_i       (mem_wdata),
        .reg_write_data_i  (reg_data),
        .reg_write_addr_i  (reg_addr),
        .reg_write_en_i    (reg_en),
        .stall_req_o       (stall),
        .addr_err_o        (addr_err),
        .data_req_valid_o  (req_valid),
        .data_req_ready_i  (req_ready),
        .data_req_wr_o     (req_wr),
        .data_req_addr_o   (req_addr),
        .data_req_wstrb_o  (req_wstrb),
        .data_req_wdata_o  (req_wdata),
        .data_resp_valid_i (resp_valid),
        .data_resp_rdata_i (resp_rdata),
        .wb_write_data_o   (wb_data),
        .wb_write_addr_o   (wb_addr),
        .wb_write_en_o     (wb_en)
    );

    task automatic set_idle_inputs();
        mem_op = OP_NOP; mem_addr = '0; mem_wdata = '0;
        reg_data = '0; reg_addr = '0; reg_en = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    endtask

    // Called at a negedge; returns at the negedge after the completing edge.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input logic [4:0] ra, input logic re,
                             input int waits, input int gap);
        int ph = 0;
        int wc = 0;
        int gc = 0;
        mem_op = op; mem_addr = addr; mem_wdata = wd;
        reg_data = 32'hDEAD_0000; reg_addr = ra; reg_en = re;
        o_seen = 0; o_wr = 0; o_done = 0; o_stall_resp = 1'b1;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_stall_cnt = 0;
        for (int c = 0; c < 40 && !o_done; c++) begin
            req_ready = (ph == 1 && wc == waits);
            resp_valid = (ph == 2 && gc == gap);
            resp_rdata = resp_valid ? rdat : 32'h0;
            #1;
            if (stall) o_stall_cnt++;
            if (resp_valid) o_stall_resp = stall;
            if (req_valid) begin
                o_seen = 1; o_wr = req_wr; o_addr = req_addr;
                o_wdata = req_wdata; o_wstrb = req_wstrb;
            end
            @(posedge clk);
            case (ph)
                0: ph = 1;
                1: if (req_ready) ph = 2; else wc++;
                default: if (resp_valid) o_done = 1; else gc++;
            endcase
            @(negedge clk);
            req_ready = 1'b0; resp_valid = 1'b0;
        end
        mem_op = OP_NOP; reg_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (wb_en !== 1'b0 || wb_data !== 32'h0 || wb_addr !== 5'h0) begin
            errors++; $display("FAIL reset_wb: got en=%b data=%h addr=%h want 0/0/0", wb_en, wb_data, wb_addr);
        end
        checks++; if (req_valid !== 1'b0 || stall !== 1'b0 || addr_err !== 1'b0 || req_addr !== 32'h0 || req_wstrb !== 4'h0) begin
            errors++; $display("FAIL reset_ctl: got valid=%b stall=%b err=%b addr=%h wstrb=%h want all 0",
                               req_valid, stall, addr_err, req_addr, req_wstrb);
        end
        rst = 1'b0;
    endtask

    task automatic test_nop();
        mem_op = OP_NOP; reg_data = 32'h1234; reg_addr = 5'd3; reg_en = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL nop_stall: got %b want 0", stall);
        end
        @(negedge clk);
        checks++; if (wb_data !== 32'h1234 || wb_addr !== 5'd3 || wb_en !== 1'b1) begin
            errors++; $display("FAIL nop_wb: got %h/%0d/%b want 00001234/3/1", wb_data, wb_addr, wb_en);
        end
        reg_data = 32'h5678; reg_addr = 5'd9; reg_en = 1'b0;
        @(negedge clk);
        checks++; if (wb_data !== 32'h5678 || wb_addr !== 5'd9 || wb_en !== 1'b0) begin
            errors++; $display("FAIL nop_b2b: got %h/%0d/%b want 00005678/9/0", wb_data, wb_addr, wb_en);
        end
    endtask

    task automatic test_lb();
        do_access(OP_LB, 32'h1003, 32'h0, 32'h80FF_FFFF, 5'd7, 1'b1, 2, 1);
        checks++; if (o_done !== 1'b1 || o_seen !== 1'b1) begin
            errors++; $display("FAIL lb_done: got done=%b seen=%b want 1/1", o_done, o_seen);
        end
        checks++; if (o_addr !== 32'h1000 || o_wr !== 1'b0) begin
            errors++; $display("FAIL lb_req: got addr=%h wr=%b want 00001000/0", o_addr, o_wr);
        end
        checks++; if (o_stall_cnt != 5 || o_stall_resp !== 1'b0) begin
            errors++; $display("FAIL lb_stall: got cnt=%0d at_resp=%b want 5/0", o_stall_cnt, o_stall_resp);
        end
        checks++; if (wb_data !== 32'hFFFF_FF80 || wb_addr !== 5'd7 || wb_en !== 1'b1) begin
            errors++; $display("FAIL lb_wb: got %h/%0d/%b want ffffff80/7/1", wb_data, wb_addr, wb_en);
        end
    endtask

    task automatic test_lhu_lh();
        do_access(OP_LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 5'd4, 1'b1, 0, 0);
        checks++; if (o_done !== 1'b1 || wb_data !== 32'h0000_BEEF || wb_en !== 1'b1 || o_addr !== 32'h2000) begin
            errors++; $display("FAIL lhu: got done=%b data=%h en=%b addr=%h want 1/0000beef/1/00002000",
                               o_done, wb_data, wb_en, o_addr);
        end
        checks++; if (o_stall_cnt != 2) begin
            errors++; $display("FAIL lhu_stall: got %0d want 2", o_stall_cnt);
        end
        do_access(OP_LH, 32'h2000, 32'h0, 32'h1234_8001, 5'd5, 1'b1, 1, 0);
        checks++; if (o_done !== 1'b1 || wb_data !== 32'hFFFF_8001 || wb_addr !== 5'd5) begin
            errors++; $display("FAIL lh: got done=%b data=%h addr=%0d want 1/ffff8001/5", o_done, wb_data, wb_addr);
        end
    endtask

    task automatic test_stores();
        do_access(OP_SB, 32'h3001, 32'h0000_00AA, 32'h0, 5'd0, 1'b0, 0, 2);
        checks++; if (o_done !== 1'b1 || o_wstrb !== 4'b0010 || o_wdata !== 32'hAAAA_AAAA || o_wr !== 1'b1 || o_addr !== 32'h3000) begin
            errors++; $display("FAIL sb_req: got done=%b wstrb=%b wdata=%h wr=%b addr=%h want 1/0010/aaaaaaaa/1/00003000",
                               o_done, o_wstrb, o_wdata, o_wr, o_addr);
        end
        checks++; if (wb_en !== 1'b0) begin
            errors++; $display("FAIL sb_wb: got en=%b want 0", wb_en);
        end
        do_access(OP_SH, 32'h5002, 32'h0000_1234, 32'h0, 5'd0, 1'b0, 0, 0);
        checks++; if (o_wstrb !== 4'b1100 || o_wdata !== 32'h1234_1234 || o_wr !== 1'b1) begin
            errors++; $display("FAIL sh_req: got wstrb=%b wdata=%h wr=%b want 1100/12341234/1", o_wstrb, o_wdata, o_wr);
        end
        do_access(OP_SW, 32'h6000, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 1, 1);
        checks++; if (o_wstrb !== 4'b1111 || o_wdata !== 32'hCAFE_F00D || o_addr !== 32'h6000) begin
            errors++; $display("FAIL sw_req: got wstrb=%b wdata=%h addr=%h want 1111/cafef00d/00006000", o_wstrb, o_wdata, o_addr);
        end
    endtask

    task automatic test_misaligned();
        logic seen_valid = 1'b0;
        mem_op = OP_LW; mem_addr = 32'h4002; reg_addr = 5'd6; reg_en = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL mis_stall: got stall=%b valid=%b want 0/0", stall, req_valid);
        end
        @(negedge clk);
        checks++; if (addr_err !== 1'b1 || wb_en !== 1'b0) begin
            errors++; $display("FAIL mis_err: got err=%b wb_en=%b want 1/0", addr_err, wb_en);
        end
        mem_op = OP_NOP; reg_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (req_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (addr_err !== 1'b0 || seen_valid !== 1'b0) begin
            errors++; $display("FAIL mis_pulse: got err=%b valid_seen=%b want 0/0", addr_err, seen_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        mem_op = OP_LW; mem_addr = 32'h7000; reg_addr = 5'd8; reg_en = 1'b1; reg_data = 32'h0;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        checks++; if (stall !== 1'b1 || req_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resp: got stall=%b valid=%b want 1/0", stall, req_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_op = OP_NOP; mem_addr = '0; reg_addr = '0; reg_en = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || req_valid !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_state: got stall=%b valid=%b wb_en=%b wb_data=%h want 0/0/0/0",
                               stall, req_valid, wb_en, wb_data);
        end
        resp_valid = 1'b1; resp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        resp_valid = 1'b0;
        checks++; if (wb_en !== 1'b0 || wb_data !== 32'h0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_late_resp: got wb_en=%b wb_data=%h stall=%b want 0/0/0", wb_en, wb_data, stall);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_nop();
        test_lb();
        test_lhu_lh();
        test_stores();
        test_misaligned();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
